rx_segment_dispatcher: RTL and testbench

Front-end scheduler for the bank of rx_majority instances. It extracts the 16-bit segment number from each received frame and keeps a slot table mapping segment numbers to majority instances. Redundant copies of the same segment go to the slot that already holds it; a new segment gets a free slot. Frame bytes pass through a fixed-latency delay line, so the selected slot's enable is asserted from byte 0 of the frame.

---
 rtl/rx_seg_pkg.sv | 21 ++
 rtl/rx_seg_slot_table.sv | 67 ++++++
 rtl/rx_segment_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_rx_segment_dispatcher.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_seg_pkg.sv
// Shared constants and types for the rx segment dispatcher.
package rx_seg_pkg;

  localparam int SEG_W         = 16;
  localparam int SEG_POS_DEF   = 22;
  localparam int NUM_SLOTS_DEF = 8;

  // Input register + delay line + output register give the byte latency.
  function automatic int lat_of(input int seg_pos);
    return seg_pos + 3;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOOKUP,
    S_STREAM,
    S_DROP
  } state_t;

endpackage

// File: rtl/rx_seg_slot_table.sv
// Segment-to-slot table: tags, valid bits, parallel compare, lowest-free
// pick, and the release/allocate update with the free-slot count.
module rx_seg_slot_table
  import rx_seg_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup,
  input  logic [SEG_W-1:0]     tag,
  input  logic [NUM_SLOTS-1:0] rel,
  output logic                 found,
  output logic                 hit,
  output logic [SLOT_W-1:0]    slot,
  output logic [SLOT_W:0]      slots_free
);

  logic [NUM_SLOTS-1:0][SEG_W-1:0] tags;
  logic [NUM_SLOTS-1:0]            valid, live, valid_nxt;
  logic [SLOT_W-1:0]               hit_idx, free_idx;
  logic                            free_any, alloc;
  logic [SLOT_W:0]                 used_nxt;

  // Releases land first, so the lookup sees the post-release table.
  always_comb begin
    live     = valid & ~rel;
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (live[i] && tags[i] == tag) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
      if (!live[i]) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
    found     = hit | free_any;
    slot      = hit ? hit_idx : free_idx;
    alloc     = lookup & ~hit & free_any;
    valid_nxt = live;
    if (alloc) valid_nxt[free_idx] = 1'b1;
    used_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      used_nxt = used_nxt + {{SLOT_W{1'b0}}, valid_nxt[i]};
  end

  // Table state; free count is derived from the next valid set so it can
  // never drift, underflow or overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      tags       <= '0;
      slots_free <= (SLOT_W+1)'(NUM_SLOTS);
    end else begin
      valid      <= valid_nxt;
      if (alloc) tags[free_idx] <= tag;
      slots_free <= (SLOT_W+1)'(NUM_SLOTS) - used_nxt;
    end
  end

endmodule

// File: rtl/rx_segment_dispatcher.sv
// Front-end scheduler: pulls the segment number out of each frame, binds the
// frame to a majority slot and replays the bytes through a fixed delay line
// so the chosen slot is enabled from byte 0.
module rx_segment_dispatcher
  import rx_seg_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SEG_POS   = SEG_POS_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 rx_clk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic [7:0]           rx_data,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic [7:0]           slot_data,
  output logic                 dispatch_valid,
  output logic [SLOT_W-1:0]    dispatch_slot,
  output logic                 dispatch_hit,
  output logic                 frame_drop,
  output logic                 short_frame,
  output logic [SLOT_W:0]      slots_free
);

  localparam int DL_DEPTH = lat_of(SEG_POS) - 1;
  localparam int IDX_W    = $clog2(SEG_POS + 2);

  logic                           en_r, prev_en, start_r;
  logic [7:0]                     dat_r;
  logic [IDX_W-1:0]               idx;
  logic [SEG_W-1:0]               seg;
  state_t                         state, state_nxt;
  logic                           do_lookup, do_short;
  logic [NUM_SLOTS-1:0]           protect;
  logic                           tbl_found, tbl_hit;
  logic [SLOT_W-1:0]              tbl_slot;
  logic                           sel_valid;
  logic [SLOT_W-1:0]              sel;
  logic [DL_DEPTH-1:0]            vld_pipe;
  logic [DL_DEPTH-1:0][7:0]       dat_pipe;
  logic [DL_DEPTH-2:0]            kill;

  // Input register; prev_en resets high so a frame already running at
  // reset release is ignored until the line goes idle.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      en_r    <= 1'b0;
      dat_r   <= '0;
      prev_en <= 1'b1;
      start_r <= 1'b0;
    end else begin
      en_r    <= rx_enable;
      dat_r   <= rx_data;
      prev_en <= rx_enable;
      start_r <= rx_enable & ~prev_en;
    end
  end

  // Byte index (saturating past the header) and segment-number capture.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      seg <= '0;
    end else begin
      if (!en_r)                                idx <= '0;
      else if (idx != IDX_W'(SEG_POS + 1))      idx <= idx + 1'b1;
      if (en_r && idx == IDX_W'(SEG_POS - 1))   seg[15:8] <= dat_r;
      if (en_r && idx == IDX_W'(SEG_POS))       seg[7:0]  <= dat_r;
    end
  end

  // FSM state register.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_r) state_nxt = S_HEADER;
      S_HEADER: if (!en_r) state_nxt = S_IDLE;
                else if (idx == IDX_W'(SEG_POS)) state_nxt = S_LOOKUP;
      S_LOOKUP: if (!en_r) state_nxt = S_IDLE;
                else state_nxt = tbl_found ? S_STREAM : S_DROP;
      S_STREAM: if (!en_r) state_nxt = S_IDLE;
      S_DROP:   if (!en_r) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: lookup strobe, short-frame kill mask, streaming-slot guard.
  always_comb begin
    do_lookup = (state == S_LOOKUP);
    do_short  = (state == S_HEADER) && !en_r;
    protect   = '0;
    if (sel_valid && state == S_STREAM) protect[sel] = 1'b1;
    for (int i = 0; i < DL_DEPTH - 1; i++)
      kill[i] = do_short && (IDX_W'(i) < idx);
  end

  rx_seg_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_table (
    .clk        (rx_clk),
    .rst_n      (reset),
    .lookup     (do_lookup),
    .tag        (seg),
    .rel        (slot_done & ~protect),
    .found      (tbl_found),
    .hit        (tbl_hit),
    .slot       (tbl_slot),
    .slots_free (slots_free)
  );

  // Selection and dispatch status, loaded once per frame at lookup.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      sel_valid      <= 1'b0;
      sel            <= '0;
      dispatch_valid <= 1'b0;
      dispatch_slot  <= '0;
      dispatch_hit   <= 1'b0;
      frame_drop     <= 1'b0;
      short_frame    <= 1'b0;
    end else begin
      dispatch_valid <= do_lookup & tbl_found;
      dispatch_hit   <= do_lookup & tbl_hit;
      frame_drop     <= do_lookup & ~tbl_found;
      short_frame    <= do_short;
      if (do_lookup) begin
        sel_valid <= tbl_found;
        sel       <= tbl_slot;
        if (tbl_found) dispatch_slot <= tbl_slot;
      end
    end
  end

  // Delay line; a short frame wipes the valid bits of its own bytes only.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DL_DEPTH-2:0] & ~kill, en_r};
      dat_pipe <= {dat_pipe[DL_DEPTH-2:0], dat_r};
    end
  end

  // Output stage: shared data byte plus one-hot enable of the selection.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      slot_en   <= '0;
      slot_data <= '0;
    end else begin
      slot_data <= dat_pipe[DL_DEPTH-1];
      slot_en   <= (vld_pipe[DL_DEPTH-1] && sel_valid) ? (NUM_SLOTS'(1) << sel) : '0;
    end
  end

endmodule

// File: tb/tb_rx_segment_dispatcher.sv
// Bench for rx_segment_dispatcher: a frame-level model schedules expected
// outputs per cycle; one compare process checks them every cycle.
module tb_rx_segment_dispatcher;

  localparam int NS   = 8;
  localparam int SP   = 22;
  localparam int SW   = 3;
  localparam int LAT  = SP + 3;
  localparam int MAXC = 4096;

  logic          rx_clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_enable = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [NS-1:0] slot_done = '0;
  logic [NS-1:0] slot_en;
  logic [7:0]    slot_data;
  logic          dispatch_valid;
  logic [SW-1:0] dispatch_slot;
  logic          dispatch_hit;
  logic          frame_drop;
  logic          short_frame;
  logic [SW:0]   slots_free;

  rx_segment_dispatcher #(.NUM_SLOTS(NS), .SEG_POS(SP)) dut (
    .rx_clk         (rx_clk),
    .reset          (reset),
    .rx_enable      (rx_enable),
    .rx_data        (rx_data),
    .slot_done      (slot_done),
    .slot_en        (slot_en),
    .slot_data      (slot_data),
    .dispatch_valid (dispatch_valid),
    .dispatch_slot  (dispatch_slot),
    .dispatch_hit   (dispatch_hit),
    .frame_drop     (frame_drop),
    .short_frame    (short_frame),
    .slots_free     (slots_free)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Expected outputs per cycle.
  int exp_en[MAXC], exp_dat[MAXC], exp_dv[MAXC], exp_slot[MAXC];
  int exp_hit[MAXC], exp_drop[MAXC], exp_short[MAXC], free_chg[MAXC];
  int cur_free = NS;
  bit chk_on = 1'b0;

  // Frame-level table model.
  bit          m_valid[NS];
  logic [15:0] m_tag[NS];

  // Observation counters for literal pins.
  int en0_cnt = 0, first_en = -1, drop_cnt = 0, short_cnt = 0, last_slot = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [7:0] fbyte(input logic [15:0] seg, input int i);
    if (i == SP - 1) return seg[15:8];
    if (i == SP)     return seg[7:0];
    return 8'(i * 7 + int'(seg) * 13 + 1);
  endfunction

  function automatic int count_free();
    int n = 0;
    for (int i = 0; i < NS; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  task automatic clear_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_en[k] = 0; exp_dat[k] = 0; exp_dv[k] = 0; exp_slot[k] = 0;
      exp_hit[k] = 0; exp_drop[k] = 0; exp_short[k] = 0; free_chg[k] = -1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    cur_free = NS;
  endtask

  // Decide the frame's fate from the table rules, schedule its outputs,
  // then drive it followed by one idle cycle.
  task automatic send_frame(input logic [15:0] seg, input int len,
                            input logic [NS-1:0] rel, input int rel_at,
                            output int n0);
    int s;
    bit h;
    n0 = cyc + 1;
    if (len <= SP) begin
      exp_short[n0 + len + 1] = 1;
    end else begin
      for (int i = 0; i < NS; i++) if (rel[i]) m_valid[i] = 1'b0;
      s = -1;
      h = 1'b0;
      for (int i = 0; i < NS; i++)
        if (s < 0 && m_valid[i] && m_tag[i] == seg) begin s = i; h = 1'b1; end
      if (s < 0)
        for (int i = 0; i < NS; i++) if (s < 0 && !m_valid[i]) s = i;
      if (s < 0) begin
        exp_drop[n0 + SP + 2] = 1;
      end else begin
        if (!h) begin m_valid[s] = 1'b1; m_tag[s] = seg; end
        exp_dv[n0 + SP + 2]   = 1;
        exp_slot[n0 + SP + 2] = s;
        exp_hit[n0 + SP + 2]  = int'(h);
        for (int i = 0; i < len; i++) begin
          exp_en[n0 + i + LAT]  = 1 << s;
          exp_dat[n0 + i + LAT] = int'(fbyte(seg, i));
        end
      end
      free_chg[n0 + SP + 2] = count_free();
    end
    for (int i = 0; i < len; i++) begin
      rx_enable = 1'b1;
      rx_data   = fbyte(seg, i);
      slot_done = (i == rel_at) ? rel : '0;
      tick();
    end
    rx_enable = 1'b0;
    rx_data   = '0;
    slot_done = '0;
    tick();
  endtask

  task automatic pulse_done(input logic [NS-1:0] m);
    int n;
    n = cyc + 1;
    for (int i = 0; i < NS; i++) if (m[i]) m_valid[i] = 1'b0;
    free_chg[n] = count_free();
    slot_done = m;
    tick();
    slot_done = '0;
  endtask

  // Per-cycle compare against the model schedule.
  always @(negedge rx_clk) begin
    if (free_chg[cyc] >= 0) cur_free = free_chg[cyc];
    if (chk_on) begin
      chk("slot_en", int'(slot_en), exp_en[cyc]);
      if (exp_en[cyc] != 0) chk("slot_data", int'(slot_data), exp_dat[cyc]);
      chk("dispatch_valid", int'(dispatch_valid), exp_dv[cyc]);
      if (exp_dv[cyc] != 0) begin
        chk("dispatch_slot", int'(dispatch_slot), exp_slot[cyc]);
        chk("dispatch_hit", int'(dispatch_hit), exp_hit[cyc]);
      end
      chk("frame_drop", int'(frame_drop), exp_drop[cyc]);
      chk("short_frame", int'(short_frame), exp_short[cyc]);
      chk("slots_free", int'(slots_free), cur_free);
    end
  end

  // Observation counters.
  always @(negedge rx_clk) begin
    if (slot_en == 8'h01) begin
      if (first_en < 0) first_en = cyc;
      en0_cnt++;
    end
    if (frame_drop)     drop_cnt++;
    if (short_frame)    short_cnt++;
    if (dispatch_valid) last_slot = int'(dispatch_slot);
  end

  initial begin
    int n0, n1;
    clear_from(0);
    model_reset();

    // Reset state.
    reset = 1'b0;
    idle(3);
    chk("reset_slot_en", int'(slot_en), 0);
    chk("reset_dispatch", int'(dispatch_valid), 0);
    chk("reset_slots_free", int'(slots_free), 8);
    reset = 1'b1;
    tick();
    chk_on = 1'b1;
    idle(2);

    // Single 64-byte frame into an empty table.
    send_frame(16'h0005, 64, '0, -1, n0);
    idle(30);
    chk("t1_en0_cycles", en0_cnt, 64);
    chk("t1_latency", first_en - n0, 25);
    chk("t1_slots_free", int'(slots_free), 7);
    chk("t1_slot", last_slot, 0);

    // Three redundant copies with 1-cycle gaps.
    send_frame(16'h0005, 64, '0, -1, n0);
    send_frame(16'h0005, 64, '0, -1, n0);
    send_frame(16'h0005, 64, '0, -1, n0);
    idle(30);
    chk("t2_en0_cycles", en0_cnt, 256);
    chk("t2_slots_free", int'(slots_free), 7);

    // Free slot 0, then nine distinct segments fill the table and drop one.
    pulse_done(8'h01);
    idle(2);
    for (int k = 0; k < 9; k++) send_frame(16'h0010 + 16'(k), 40, '0, -1, n0);
    idle(30);
    chk("t3_slots_free", int'(slots_free), 0);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_last_slot", last_slot, 7);

    // Table full; slot 3 released in the lookup cycle is reallocated.
    send_frame(16'h0018, 40, 8'h08, SP + 2, n0);
    idle(30);
    chk("t4_slot", last_slot, 3);
    chk("t4_slots_free", int'(slots_free), 0);
    chk("t4_drop_cnt", drop_cnt, 1);

    // Short frame then a normal frame after a 1-cycle gap.
    pulse_done(8'h01);
    idle(2);
    send_frame(16'h0055, 10, '0, -1, n0);
    send_frame(16'h0020, 64, '0, -1, n1);
    idle(30);
    chk("t5_short_cnt", short_cnt, 1);
    chk("t5_slot", last_slot, 0);
    chk("t5_gap", n1 - n0, 11);

    // Reset mid-frame, release while the frame is still running.
    idle(5);
    for (int i = 0; i < 15; i++) begin
      rx_enable = 1'b1;
      rx_data   = fbyte(16'h0030, i);
      tick();
    end
    reset = 1'b0;
    clear_from(cyc);
    model_reset();
    tick();
    chk("t6_rst_slot_en", int'(slot_en), 0);
    chk("t6_rst_dispatch", int'(dispatch_valid), 0);
    chk("t6_rst_slots_free", int'(slots_free), 8);
    idle(2);
    reset = 1'b1;
    for (int i = 15; i < 45; i++) begin
      rx_data = fbyte(16'h0030, i);
      tick();
    end
    rx_enable = 1'b0;
    rx_data   = '0;
    idle(2);
    last_slot = -1;
    send_frame(16'h0031, 64, '0, -1, n0);
    idle(30);
    chk("t6_slot", last_slot, 0);
    chk("t6_slots_free", int'(slots_free), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
